dmem_access_ctrl: RTL
=====================

// Module: dmem_access_ctrl
// PURPOSE
//  Sequences MEM-stage data-memory accesses onto a multi-cycle req/ack memory port.
//  - Consumes the 2-bit MemRead/MemWrite access codes: 0 = no access, 1 = byte, 2 = half, 3 = word.
//  - Generates byte enables and write-lane replication; extracts and sign-extends read data.
//  - Raises stall_o to freeze the pipeline; stall_o drives the Control unit's Stall_i path and hazard logic.
// PARAMETERS
//  TIMEOUT_CYCLES  255  max BUSY cycles waiting for mem_ack_i (used only with DMEM_TIMEOUT_EN)
//  CNT_W           8    width of the timeout counter; must hold TIMEOUT_CYCLES
// PORTS
//  clk_i        in   1   clock; all state updates on rising edge
//  rst_i        in   1   asynchronous, active-low reset
//  memread_i    in   2   read access code from MEM stage
//  memwrite_i   in   2   write access code from MEM stage
//  addr_i       in   32  byte address (ALU result)
//  wdata_i      in   32  store data (rt value)
//  rdata_o      out  32  load result, sign-extended for byte/half
//  stall_o      out  1   freeze IF..MEM pipeline registers
//  misalign_o   out  1   one-cycle pulse: misaligned access rejected
//  err_o        out  1   sticky error (misalign or timeout); cleared only by reset
//  mem_req_o    out  1   memory request, level, held until ack
//  mem_we_o     out  1   1 = write, 0 = read
//  mem_addr_o   out  32  word address {addr[31:2],2'b00}
//  mem_be_o     out  4   byte enables
//  mem_wdata_o  out  32  write data, lane-replicated
//  mem_ack_i    in   1   memory completion, one-cycle pulse
//  mem_rdata_i  in   32  read data, valid with mem_ack_i
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0 (rdata_o, stall_o, misalign_o, err_o, mem_*); timeout counter 0.
//  FSM IDLE -> BUSY -> DONE -> IDLE.
//  IDLE
//   - Both codes 0: no action.
//   - Both codes nonzero (illegal): no access; misalign_o=1 next cycle; err_o set.
//   - Misaligned (half with addr[0]=1, word with addr[1:0]!=0): no request; misalign_o=1 next cycle; err_o set; stall_o stays 0.
//   - Valid access: stall_o=1 combinationally in that cycle; latch addr/be/we/wdata/size; go BUSY.
//  BUSY
//   - stall_o=1 and mem_req_o=1 (registered); mem_addr/be/we/wdata stable.
//   - On mem_ack_i: capture data; go DONE.
//  DONE
//   - stall_o=0, mem_req_o=0, rdata_o valid for exactly this cycle.
//   - Pipeline advances at the end of DONE; the same access still on the inputs is not re-issued.
//   - Unconditional transition to IDLE.
//  Latency: ack in first BUSY cycle gives 2 stall cycles; N extra wait cycles give 2+N.
//  Byte enables: byte = 4'b0001<<addr[1:0]; half = addr[1] ? 4'b1100 : 4'b0011; word = 4'b1111.
//  Write lanes: byte {4{wdata[7:0]}}; half {2{wdata[15:0]}}; word wdata.
//  Read: selected lane, sign-extended to 32 bits for byte/half.
//  Writes: rdata_o=0 in DONE.
//  Ack outside BUSY (IDLE/DONE): ignored.
//  Reset mid-access: immediate return to IDLE; mem_req_o drops asynchronously; late ack ignored.
//  misalign_o is high for exactly one cycle per rejected access.
// CONFIGURATION
//  DMEM_TIMEOUT_EN defined
//   - Counter increments each BUSY cycle.
//   - Reaching TIMEOUT_CYCLES without ack aborts to DONE: rdata_o=0, err_o set, mem_req_o drops.
//  DMEM_TIMEOUT_EN undefined
//   - No counter; BUSY waits indefinitely; err_o is set only by misalign/illegal cases.
// TESTING
//  T1  lw, addr=0x10, ack 1st BUSY cycle, mem_rdata=0xDEADBEEF
//      -> stall 2 cycles, be=4'hF, we=0, rdata_o=0xDEADBEEF in DONE.
//  T2  sb, addr=0x13, wdata=0x000000A5, ack after 3 waits
//      -> be=4'b1000, mem_wdata=0xA5A5A5A5, stall 5 cycles, mem_addr=0x10.
//  T3  lb, addr=0x21, mem_rdata=0x0000_8000
//      -> rdata_o=0xFFFFFF80; lh at 0x22 with 0x8001_0000 -> rdata_o=0xFFFF8001.
//  T4  lw at addr=0x06 -> no mem_req_o, stall_o=0, misalign_o 1-cycle pulse, err_o=1 held.
//  T5  rst_i low during BUSY, then stray ack
//      -> mem_req_o=0 immediately, state IDLE, stray ack no effect, all outputs 0.
//  T6  DMEM_TIMEOUT_EN, TIMEOUT_CYCLES=4, no ack
//      -> abort after 4 BUSY cycles, err_o=1, rdata_o=0, stall_o drops in DONE.

Source files
------------

// File: rtl/dmem_access_ctrl_if.sv
// Memory-port bundle between the MEM-stage access controller and the data memory.
// The controller side uses the master modport, the memory side uses the slave modport.
interface dmem_access_ctrl_if;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_wdata_o;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i;

    modport master (
        output mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o,
        input  mem_ack_i, mem_rdata_i
    );

    modport slave (
        input  mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o,
        output mem_ack_i, mem_rdata_i
    );
endinterface

// File: rtl/dmem_access_ctrl.sv
// MEM-stage data-memory sequencer: turns byte/half/word load/store codes into a req/ack transaction.
// Optional BUSY timeout abort is enabled by defining DMEM_TIMEOUT_EN.
module dmem_access_ctrl #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [1:0]  memread_i,
    input  logic [1:0]  memwrite_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic        stall_o,
    output logic        misalign_o,
    output logic        err_o,
    dmem_access_ctrl_if.master mem
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t      state_r;
    state_t      state_nxt_s;

    logic [1:0]  code_s;
    logic        is_write_s;
    logic        illegal_s;
    logic        misal_s;
    logic        reject_s;
    logic        start_s;
    logic        finish_s;
    logic        timeout_s;

    logic        misalign_r;
    logic        err_r;
    logic [31:0] rdata_r;
    logic        req_r;
    logic        we_r;
    logic [31:0] addr_r;
    logic [3:0]  be_r;
    logic [31:0] wdata_r;
    logic [1:0]  size_r;
    logic [1:0]  off_r;

    function automatic logic [3:0] calc_be(input logic [1:0] size, input logic [1:0] off);
        case (size)
            2'd1:    calc_be = 4'b0001 << off;
            2'd2:    calc_be = off[1] ? 4'b1100 : 4'b0011;
            2'd3:    calc_be = 4'b1111;
            default: calc_be = 4'b0000;
        endcase
    endfunction

    function automatic logic [31:0] lane_wdata(input logic [1:0] size, input logic [31:0] d);
        case (size)
            2'd1:    lane_wdata = {4{d[7:0]}};
            2'd2:    lane_wdata = {2{d[15:0]}};
            default: lane_wdata = d;
        endcase
    endfunction

    function automatic logic [31:0] read_extract(input logic [1:0] size, input logic [1:0] off,
                                                 input logic [31:0] d);
        logic [7:0]  b;
        logic [15:0] h;
        case (off)
            2'd0:    b = d[7:0];
            2'd1:    b = d[15:8];
            2'd2:    b = d[23:16];
            default: b = d[31:24];
        endcase
        h = off[1] ? d[31:16] : d[15:0];
        case (size)
            2'd1:    read_extract = {{24{b[7]}}, b};
            2'd2:    read_extract = {{16{h[15]}}, h};
            default: read_extract = d;
        endcase
    endfunction

    // Request decode; an illegal read+write combination is treated like a misaligned access
    always_comb begin
        code_s     = memread_i | memwrite_i;
        is_write_s = (memwrite_i != 2'd0);
        illegal_s  = (memread_i != 2'd0) && (memwrite_i != 2'd0);
        misal_s    = ((code_s == 2'd2) && addr_i[0]) ||
                     ((code_s == 2'd3) && (addr_i[1:0] != 2'b00));
        reject_s   = (state_r == ST_IDLE) && (illegal_s || ((code_s != 2'd0) && misal_s));
        start_s    = (state_r == ST_IDLE) && (code_s != 2'd0) && !illegal_s && !misal_s;
        finish_s   = (state_r == ST_BUSY) && (mem.mem_ack_i || timeout_s);
    end

`ifdef DMEM_TIMEOUT_EN
    logic [CNT_W-1:0] cnt_r;

    // BUSY-cycle counter, restarted whenever the FSM is outside BUSY
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (state_r == ST_BUSY) begin
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= {CNT_W{1'b0}};
        end
    end

    assign timeout_s = (state_r == ST_BUSY) && !mem.mem_ack_i &&
                       (cnt_r == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_s = 1'b0;
`endif

    // State register
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic and pipeline stall (stall is combinational on the issuing IDLE cycle)
    always_comb begin
        state_nxt_s = state_r;
        stall_o     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start_s) begin
                    state_nxt_s = ST_BUSY;
                    stall_o     = 1'b1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                stall_o = 1'b1;
                if (finish_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_BUSY;
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Memory-port, load-result and error registers
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            misalign_r <= 1'b0;
            err_r      <= 1'b0;
            rdata_r    <= 32'h0000_0000;
            req_r      <= 1'b0;
            we_r       <= 1'b0;
            addr_r     <= 32'h0000_0000;
            be_r       <= 4'b0000;
            wdata_r    <= 32'h0000_0000;
            size_r     <= 2'd0;
            off_r      <= 2'd0;
        end else begin
            misalign_r <= reject_s;
            if (reject_s || (finish_s && !mem.mem_ack_i)) begin
                err_r <= 1'b1;
            end
            if (start_s) begin
                req_r   <= 1'b1;
                we_r    <= is_write_s;
                addr_r  <= {addr_i[31:2], 2'b00};
                be_r    <= calc_be(code_s, addr_i[1:0]);
                wdata_r <= lane_wdata(code_s, wdata_i);
                size_r  <= code_s;
                off_r   <= addr_i[1:0];
            end else if (finish_s) begin
                req_r <= 1'b0;
            end
            // Load data lives in rdata_r only for the DONE cycle that follows completion
            if (finish_s && mem.mem_ack_i && !we_r) begin
                rdata_r <= read_extract(size_r, off_r, mem.mem_rdata_i);
            end else begin
                rdata_r <= 32'h0000_0000;
            end
        end
    end

    assign rdata_o         = rdata_r;
    assign misalign_o      = misalign_r;
    assign err_o           = err_r;
    assign mem.mem_req_o   = req_r;
    assign mem.mem_we_o    = we_r;
    assign mem.mem_addr_o  = addr_r;
    assign mem.mem_be_o    = be_r;
    assign mem.mem_wdata_o = wdata_r;

endmodule
